// File: rtl/ex_operand_stage.sv
// Single-entry operand stage between decode and the ALU: holds one instruction, resolves SrcA/SrcB/store_data.
// Define EX_OPERAND_FWD_EN to forward from EX/MEM and MEM/WB; otherwise hazards stall the entry in WAIT.
module ex_operand_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR_W    = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [REG_ADDR_W-1:0]    rs1_addr,
    input  logic [REG_ADDR_W-1:0]    rs2_addr,
    input  logic [REG_ADDR_W-1:0]    rd_addr,
    input  logic [DATA_WIDTH-1:0]    rs1_data,
    input  logic [DATA_WIDTH-1:0]    rs2_data,
    input  logic [DATA_WIDTH-1:0]    imm,
    input  logic                     alu_src,
    input  logic [OPCODE_LENGTH-1:0] op_in,
    input  logic                     reg_write_in,
    input  logic                     flush,
    input  logic [REG_ADDR_W-1:0]    exmem_rd,
    input  logic [REG_ADDR_W-1:0]    memwb_rd,
    input  logic                     exmem_we,
    input  logic                     memwb_we,
    input  logic [DATA_WIDTH-1:0]    exmem_result,
    input  logic [DATA_WIDTH-1:0]    memwb_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [DATA_WIDTH-1:0]    store_data,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [REG_ADDR_W-1:0]    rd_out,
    output logic                     reg_write_out
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] FULL  = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]               state;
    logic [REG_ADDR_W-1:0]    rs1_q, rs2_q, rd_q;
    logic [DATA_WIDTH-1:0]    rs1_data_q, rs2_data_q, imm_q;
    logic                     alu_src_q, reg_write_q;
    logic [OPCODE_LENGTH-1:0] op_q;

    logic take, release_entry, clear_entry, hazard;
    logic wb_hit1, wb_hit2, ex_hit1, ex_hit2;
    logic [DATA_WIDTH-1:0] fwd_a, fwd_b;

    // Register x0 never matches, so a zero address can neither stall nor be forwarded into.
    assign ex_hit1 = exmem_we && (exmem_rd != '0) && (exmem_rd == rs1_q);
    assign ex_hit2 = exmem_we && (exmem_rd != '0) && (exmem_rd == rs2_q);
    assign wb_hit1 = memwb_we && (memwb_rd != '0) && (memwb_rd == rs1_q);
    assign wb_hit2 = memwb_we && (memwb_rd != '0) && (memwb_rd == rs2_q);

`ifdef EX_OPERAND_FWD_EN
    assign fwd_a  = ex_hit1 ? exmem_result : (wb_hit1 ? memwb_result : rs1_data_q);
    assign fwd_b  = ex_hit2 ? exmem_result : (wb_hit2 ? memwb_result : rs2_data_q);
    assign hazard = 1'b0;
`else
    logic unused_exmem_result;
    assign unused_exmem_result = ^exmem_result;
    assign fwd_a  = rs1_data_q;
    assign fwd_b  = rs2_data_q;
    assign hazard = ex_hit1 || ex_hit2 || wb_hit1 || wb_hit2;
`endif

    // A hazard seen while FULL suppresses issue in the same cycle so stale operands never leave.
    assign out_valid     = (state == FULL) && !hazard;
    assign in_ready      = (state == EMPTY) || (out_valid && out_ready);
    assign take          = in_valid && in_ready;
    assign release_entry = out_valid && out_ready;
    assign clear_entry   = flush || (release_entry && !take);

    assign SrcA          = fwd_a;
    assign SrcB          = alu_src_q ? imm_q : fwd_b;
    assign store_data    = fwd_b;
    assign Operation     = op_q;
    assign rd_out        = rd_q;
    assign reg_write_out = reg_write_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else if (flush) begin
            state <= EMPTY;
        end else if (take) begin
            state <= FULL;
        end else if (release_entry) begin
            state <= EMPTY;
        end else if (state == FULL && hazard) begin
            state <= WAIT;
        end else if (state == WAIT && !hazard) begin
            state <= FULL;
        end
    end

    // Held fields are zeroed whenever the entry goes away so an EMPTY stage drives all-zero outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            alu_src_q   <= 1'b0;
            op_q        <= '0;
            reg_write_q <= 1'b0;
        end else if (clear_entry) begin
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            alu_src_q   <= 1'b0;
            op_q        <= '0;
            reg_write_q <= 1'b0;
        end else if (take) begin
            rs1_q       <= rs1_addr;
            rs2_q       <= rs2_addr;
            rd_q        <= rd_addr;
            rs1_data_q  <= rs1_data;
            rs2_data_q  <= rs2_data;
            imm_q       <= imm;
            alu_src_q   <= alu_src;
            op_q        <= op_in;
            reg_write_q <= reg_write_in;
        end else begin
            if (wb_hit1) rs1_data_q <= memwb_result;
            if (wb_hit2) rs2_data_q <= memwb_result;
        end
    end

endmodule
